// File: rtl/reg_file_sb_if.sv
// Bus between the decode/controller side and the register file: read ports,
// ALU write port, load issue/return port and the scoreboard status outputs.
interface reg_file_sb_if #(
   parameter int W = 8,
   parameter int D = 4
);
   localparam int NREG = 2**D;

   logic            ra_en;
   logic [D-1:0]    raddrA;
   logic            rb_en;
   logic [D-1:0]    raddrB;
   logic [W-1:0]    data_outA;
   logic [W-1:0]    data_outB;
   logic            we;
   logic [D-1:0]    waddr;
   logic [W-1:0]    data_in;
   logic            ld_issue;
   logic [D-1:0]    ld_dst;
   logic            ld_valid;
   logic [D-1:0]    ld_waddr;
   logic [W-1:0]    ld_data;
   logic [NREG-1:0] busy;
   logic            ld_full;
   logic            hazard;
   logic            err;

   modport master (
      output ra_en, raddrA, rb_en, raddrB, we, waddr, data_in,
             ld_issue, ld_dst, ld_valid, ld_waddr, ld_data,
      input  data_outA, data_outB, busy, ld_full, hazard, err
   );

   modport slave (
      input  ra_en, raddrA, rb_en, raddrB, we, waddr, data_in,
             ld_issue, ld_dst, ld_valid, ld_waddr, ld_data,
      output data_outA, data_outB, busy, ld_full, hazard, err
   );
endinterface

// File: rtl/reg_file_sb.sv
// 2-read / 1-write register file with a second write port for load returns
// and a per-register pending-load scoreboard that raises a stall (hazard)
// on RAW/WAW against loads still in flight.
module reg_file_sb #(
   parameter int W       = 8,
   parameter int D       = 4,
   parameter int MAX_LD  = 4,
   parameter int ZERO_R0 = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_file_sb_if.slave  bus
);
   localparam int NREG = 2**D;
   localparam int CW   = $clog2(MAX_LD + 1);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_LD);

   logic [W-1:0]    mem [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_nxt;
   logic [NREG-1:0] eb;
   logic [CW-1:0]   cnt_q;
   // Loads to r0 never set a busy bit, so their returns are matched
   // against this separate count instead.
   logic [CW-1:0]   z_cnt_q;
   logic            err_q;

   logic ld_r0;
   logic iss_r0;
   logic ld_acc;
   logic iss_acc;
   logic we_acc;
   logic full;
   logic hz;

   // Combinational read with load-return and ALU-write bypass.
   function automatic logic [W-1:0] rd(input logic [D-1:0] a);
      logic [W-1:0] v;
      if ((ZERO_R0 != 0) && (a == '0))
         v = '0;
      else if (bus.ld_valid && (bus.ld_waddr == a))
         v = bus.ld_data;
      else if (bus.we && !hz && (bus.waddr == a))
         v = bus.data_in;
      else
         v = mem[a];
      return v;
   endfunction

   // Acceptance of returns/issues, effective busy and the stall decision.
   always_comb begin
      ld_r0  = (ZERO_R0 != 0) && (bus.ld_waddr == '0);
      iss_r0 = (ZERO_R0 != 0) && (bus.ld_dst == '0);
      ld_acc = bus.ld_valid && (ld_r0 ? (z_cnt_q != '0) : busy_q[bus.ld_waddr]);
      eb = busy_q;
      if (ld_acc)
         eb[bus.ld_waddr] = 1'b0;
      full = (cnt_q == MAXC);
      // A return that is not accepted frees no slot, which keeps the
      // counter from exceeding MAX_LD on a protocol error.
      hz = (bus.ra_en && eb[bus.raddrA])
         | (bus.rb_en && eb[bus.raddrB])
         | (bus.we && eb[bus.waddr])
         | (bus.ld_issue && (eb[bus.ld_dst] || (full && !ld_acc)));
      iss_acc = bus.ld_issue && !hz;
      we_acc  = bus.we && !hz && !((ZERO_R0 != 0) && (bus.waddr == '0));
      busy_nxt = busy_q;
      if (ld_acc && !ld_r0)
         busy_nxt[bus.ld_waddr] = 1'b0;
      if (iss_acc && !iss_r0)
         busy_nxt[bus.ld_dst] = 1'b1;
   end

   // Output drive.
   always_comb begin
      bus.data_outA = rd(bus.raddrA);
      bus.data_outB = rd(bus.raddrB);
      bus.busy      = busy_q;
      bus.ld_full   = full;
      bus.hazard    = hz;
      bus.err       = err_q;
   end

   // Register array, scoreboard, load counters and sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            mem[i] <= '0;
         busy_q  <= '0;
         cnt_q   <= '0;
         z_cnt_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (we_acc)
            mem[bus.waddr] <= bus.data_in;
         // Placed after the ALU write so load data wins on a collision.
         if (ld_acc && !ld_r0)
            mem[bus.ld_waddr] <= bus.ld_data;
         busy_q <= busy_nxt;
         case ({iss_acc, ld_acc})
            2'b10:   cnt_q <= cnt_q + ONE;
            2'b01:   cnt_q <= cnt_q - ONE;
            default: cnt_q <= cnt_q;
         endcase
         case ({iss_acc && iss_r0, ld_acc && ld_r0})
            2'b10:   z_cnt_q <= z_cnt_q + ONE;
            2'b01:   z_cnt_q <= z_cnt_q - ONE;
            default: z_cnt_q <= z_cnt_q;
         endcase
         if (bus.ld_valid && !ld_acc)
            err_q <= 1'b1;
      end
   end
endmodule
